// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Optional feature macro: CTRL_TRAP_EN adds the TRAP state for undefined opcodes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    IMM_EXEC  = 4'd10,
    IMM_WB    = 4'd11
`ifdef CTRL_TRAP_EN
    , TRAP    = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational strobe decode for the multi-cycle control FSM (Moore, except FETCH gating).
// Optional feature macro: CTRL_TRAP_EN drives the trap strobes in the TRAP state.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  state_t             state,
  input  logic [OP_W-1:0]    opCode,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memToReg,
  output logic               aluSrcA,
  output logic               regWrite,
  output logic               regDst,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         pcSource,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               trap
);

  logic [2:0] alu_code;

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    aluSrcB     = SRCB_REG;
    pcSource    = PC_ALU;
    alu_code    = ALU_ADD;
    trap        = 1'b0;
    case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE:   aluSrcB = SRCB_IMM_SH;
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      MEM_READ: begin
        iorD    = 1'b1;
        memRead = 1'b1;
      end
      MEM_WB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      MEM_WRITE: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
      end
      R_EXEC: begin
        aluSrcA  = 1'b1;
        alu_code = ALU_FUNCT;
      end
      R_WB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        alu_code    = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PC_ALUOUT;
      end
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PC_JUMP;
      end
      IMM_EXEC: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_IMM;
        alu_code = (opCode == OP_W'(OP_ORI)) ? ALU_OR : ALU_ADD;
      end
      IMM_WB:   regWrite = 1'b1;
`ifdef CTRL_TRAP_EN
      TRAP: begin
        trap     = 1'b1;
        pcWrite  = 1'b1;
        pcSource = PC_TRAP;
      end
`endif
      default: ;
    endcase
    aluOp = ALUOP_W'(alu_code);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control: state register, next-state logic and fetched-instruction counter.
// Optional feature macro: CTRL_TRAP_EN routes undefined opcodes to a one-cycle TRAP state.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opCode,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memToReg,
  output logic               aluSrcA,
  output logic               regWrite,
  output logic               regDst,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         pcSource,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               trap,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   instCount
);

  state_t cur, nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:     if (memReady) nxt = DECODE;
      DECODE: begin
        case (opCode)
          OP_W'(OP_R):                  nxt = R_EXEC;
          OP_W'(OP_LW), OP_W'(OP_SW):   nxt = MEM_ADDR;
          OP_W'(OP_BEQ):                nxt = BRANCH;
          OP_W'(OP_J):                  nxt = JUMP;
          OP_W'(OP_ADDI), OP_W'(OP_ORI): nxt = IMM_EXEC;
`ifdef CTRL_TRAP_EN
          default:                      nxt = TRAP;
`else
          default:                      nxt = FETCH;
`endif
        endcase
      end
      MEM_ADDR:  nxt = (opCode == OP_W'(OP_LW)) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (memReady) nxt = MEM_WB;
      MEM_WRITE: if (memReady) nxt = FETCH;
      R_EXEC:    nxt = R_WB;
      IMM_EXEC:  nxt = IMM_WB;
      default:   nxt = FETCH;
    endcase
  end

  mc_ctrl_decode #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .state       (cur),
    .opCode      (opCode),
    .memReady    (memReady),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .iorD        (iorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .irWrite     (irWrite),
    .memToReg    (memToReg),
    .aluSrcA     (aluSrcA),
    .regWrite    (regWrite),
    .regDst      (regDst),
    .aluSrcB     (aluSrcB),
    .pcSource    (pcSource),
    .aluOp       (aluOp),
    .trap        (trap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          instCount <= '0;
    else if (irWrite) instCount <= instCount + CNT_W'(1);
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a 32-bit and a 4-bit counter instance share stimulus.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opCode;
  logic       memReady;

  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, aluSrcA, regWrite, regDst, trap;
  logic [1:0] aluSrcB, pcSource;
  logic [2:0] aluOp;
  logic [3:0] state;
  logic [31:0] instCount;

  logic       pcWrite4, pcWriteCond4, iorD4, memRead4, memWrite4, irWrite4;
  logic       memToReg4, aluSrcA4, regWrite4, regDst4, trap4;
  logic [1:0] aluSrcB4, pcSource4;
  logic [2:0] aluOp4;
  logic [3:0] state4;
  logic [3:0] instCount4;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .aluSrcA(aluSrcA),
    .regWrite(regWrite), .regDst(regDst), .aluSrcB(aluSrcB), .pcSource(pcSource),
    .aluOp(aluOp), .trap(trap), .state(state), .instCount(instCount)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite4), .pcWriteCond(pcWriteCond4), .iorD(iorD4), .memRead(memRead4),
    .memWrite(memWrite4), .irWrite(irWrite4), .memToReg(memToReg4), .aluSrcA(aluSrcA4),
    .regWrite(regWrite4), .regDst(regDst4), .aluSrcB(aluSrcB4), .pcSource(pcSource4),
    .aluOp(aluOp4), .trap(trap4), .state(state4), .instCount(instCount4)
  );

  always #5 clk = ~clk;

  logic [17:0] act, act4;
  assign act  = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                 aluSrcA, regWrite, regDst, aluSrcB, pcSource, trap, aluOp};
  assign act4 = {pcWrite4, pcWriteCond4, iorD4, memRead4, memWrite4, irWrite4, memToReg4,
                 aluSrcA4, regWrite4, regDst4, aluSrcB4, pcSource4, trap4, aluOp4};

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected strobes packed in the same order as act.
  function automatic logic [17:0] exp_out(input int st, input logic [5:0] op, input logic rdy);
    logic pw, pwc, iord, mr, mw, irw, m2r, srca, rw, rd, tr;
    logic [1:0] srcb, pcs;
    logic [2:0] alu;
    {pw, pwc, iord, mr, mw, irw, m2r, srca, rw, rd, tr} = '0;
    srcb = 2'b00; pcs = 2'b00; alu = 3'b000;
    case (st)
      0:  begin mr = 1; srcb = 2'b01; irw = rdy; pw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin iord = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin srca = 1; alu = 3'b010; end
      7:  begin rd = 1; rw = 1; end
      8:  begin srca = 1; alu = 3'b001; pwc = 1; pcs = 2'b01; end
      9:  begin pw = 1; pcs = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; alu = (op == 6'b001101) ? 3'b100 : 3'b000; end
      11: rw = 1;
      12: begin tr = 1; pw = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, srca, rw, rd, srcb, pcs, tr, alu};
  endfunction

  typedef struct {
    int          st;
    logic [17:0] outs;
    logic [31:0] cnt;
  } rec_t;

  rec_t        q[$];
  logic [31:0] exp_cnt = '0;
  logic [5:0]  cur_op  = '0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      rec_t r;
      r = q.pop_front();
      check("state",  64'(state),      64'(r.st));
      check("outs",   64'(act),        64'(r.outs));
      check("cnt",    64'(instCount),  64'(r.cnt));
      check("state4", 64'(state4),     64'(r.st));
      check("outs4",  64'(act4),       64'(r.outs));
      check("cnt4",   64'(instCount4), 64'(r.cnt[3:0]));
    end
  end

  task automatic step(input int st, input logic rdy);
    rec_t r;
    @(posedge clk);
    #2;
    memReady = rdy;
    if (st == 1) opCode = cur_op;
    r.st   = st;
    r.outs = exp_out(st, cur_op, rdy);
    r.cnt  = exp_cnt;
    q.push_back(r);
    if (st == 0 && rdy) exp_cnt = exp_cnt + 32'd1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(0, 1'b0);
    step(0, 1'b1);
    cur_op = op;
    step(1, rnd());
    case (op)
      6'b100011: begin
        step(2, rnd());
        for (int i = 0; i < mw; i++) step(3, 1'b0);
        step(3, 1'b1);
        step(4, rnd());
      end
      6'b101011: begin
        step(2, rnd());
        for (int i = 0; i < mw; i++) step(5, 1'b0);
        step(5, 1'b1);
      end
      6'b000000: begin step(6, rnd()); step(7, rnd()); end
      6'b001000, 6'b001101: begin step(10, rnd()); step(11, rnd()); end
      6'b000100: step(8, rnd());
      6'b000010: step(9, rnd());
      default: begin
`ifdef CTRL_TRAP_EN
        step(12, rnd());
`endif
      end
    endcase
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    memReady = 1'b0;
    rst      = 1'b0;
    exp_cnt  = '0;
  endtask

  initial begin
    rst = 1'b1; memReady = 1'b0; opCode = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_outs",  64'(act), 64'(exp_out(0, 6'd0, 1'b0)));
    check("rst_cnt",   64'(instCount), 64'd0);
    release_reset();

    do_instr(6'b100011, 0, 0);            // lw: 5 cycles
    do_instr(6'b101011, 0, 3);            // sw with 3 wait cycles: 7 cycles
    do_instr(6'b000000, 0, 0);            // R
    do_instr(6'b001000, 0, 0);            // addi
    do_instr(6'b001101, 0, 0);            // ori
    do_instr(6'b000100, 0, 0);            // beq
    do_instr(6'b000010, 0, 0);            // j
    do_instr(6'b100011, 2, 2);            // lw with fetch and memory waits
    do_instr(6'b111111, 0, 0);            // undefined opcode
    do_instr(6'b010101, 1, 0);
    do_instr(6'b101011, 1, 1);

    // Asynchronous reset in the middle of a stalled store.
    step(0, 1'b1);
    cur_op = 6'b101011;
    step(1, rnd());
    step(2, rnd());
    step(5, 1'b0);
    step(5, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_state",    64'(state), 64'd0);
    check("rstmid_memWrite", 64'(memWrite), 64'd0);
    check("rstmid_cnt",      64'(instCount), 64'd0);
    check("rstmid_cnt4",     64'(instCount4), 64'd0);
    check("rstmid_trap",     64'(trap), 64'd0);
    memReady = 1'b1;
    #1;
    check("rstmid_gate", 64'({irWrite, pcWrite, memRead}), 64'b111);
    @(posedge clk);
    #1;
    check("rstmid_hold_cnt", 64'(instCount), 64'd0);
    memReady = 1'b0;
    release_reset();

    // 16 fetches wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) do_instr(6'b000010, 0, 0);
    do_instr(6'b000000, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    check("wrap_cnt4", 64'(instCount4), 64'd1);
    check("final_cnt", 64'(instCount), 64'd17);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Multi-cycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction over 3–5+ states, driving datapath strobes state by state.
- Waits on a memory-ready handshake for variable-latency memory, and counts fetched instructions.
- Sits between the instruction register (opCode) and the shared-ALU, shared-memory multi-cycle datapath.

## Interface
- OP_W, 6, opcode width
- ALUOP_W, 3, aluOp width (≥3)
- CNT_W, 32, instruction-counter width
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- opCode  input  OP_W  opcode from IR; stable except in the cycle after irWrite
- memReady  input  1  memory completes current read/write this cycle
- pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, aluSrcA, regWrite, regDst  output  1 each  datapath strobes
- aluSrcB  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
- pcSource  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 trap vector
- aluOp  output  ALUOP_W  000 add, 001 sub, 010 funct, 100 or
- trap  output  1  illegal-opcode pulse
- state  output  4  current state (debug)
- instCount  output  CNT_W  instructions fetched since reset

## Operation
- Moore FSM; outputs are combinational from state, except irWrite/pcWrite in FETCH, which are gated by memReady.
- Every output not listed for a state is 0. No x is driven in any state.
- FETCH(0): memRead=1, aluSrcA=0, aluSrcB=01, aluOp=000, pcSource=00; irWrite=pcWrite=memReady. Holds until memReady, then → DECODE.
- DECODE(1): aluSrcA=0, aluSrcB=11, aluOp=000. Next state by opcode:
  - 000000 → R_EXEC
  - 100011/101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000/001101 → IMM_EXEC
  - other → see Configuration
- MEM_ADDR(2): aluSrcA=1, aluSrcB=10, aluOp=000 → MEM_READ (lw) / MEM_WRITE (sw).
- MEM_READ(3): iorD=1, memRead=1. Holds until memReady, then → MEM_WB.
- MEM_WB(4): memToReg=1, regWrite=1, regDst=0 → FETCH.
- MEM_WRITE(5): iorD=1, memWrite=1, held stable until memReady → FETCH.
- R_EXEC(6): aluSrcA=1, aluSrcB=00, aluOp=010 → R_WB(7): regDst=1, regWrite=1 → FETCH.
- BRANCH(8): aluSrcA=1, aluSrcB=00, aluOp=001, pcWriteCond=1, pcSource=01 → FETCH. The taken decision (zero & pcWriteCond) is made in the datapath.
- JUMP(9): pcWrite=1, pcSource=10 → FETCH.
- IMM_EXEC(10): aluSrcA=1, aluSrcB=10, aluOp=000 (addi) / 100 (ori) → IMM_WB(11): regDst=0, regWrite=1 → FETCH.
- instCount increments by 1 on every cycle with irWrite=1. Wraps modulo 2^CNT_W.

## Timing
- Reset (any time, including mid-instruction):
  - state=FETCH, instCount=0 immediately.
  - Outputs show FETCH decode with memReady gating; trap=0.
  - A pending memWrite is dropped.
- Cycles with memReady held high:
  - lw 5
  - sw, R-type, addi, ori 4
  - beq, j 3
  - trap 3
- Each cycle memReady is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- memReady outside those three states is ignored.
- Counter wrap: instCount all-ones + fetch → 0.

## Configuration
- CTRL_TRAP_EN defined:
  - Undefined opcode: DECODE → TRAP(12).
  - TRAP: trap=1, pcWrite=1, pcSource=11 for one cycle → FETCH.
- CTRL_TRAP_EN undefined:
  - Undefined opcode: DECODE → FETCH (executes as nop).
  - trap tied 0; TRAP state does not exist.

## Structure
- Package mc_ctrl_pkg holds:
  - state encoding
  - opcode constants (R, LW, SW, BEQ, J, ADDI, ORI)
  - aluOp codes
  - aluSrcB codes
  - pcSource codes
- Sub-module mc_ctrl_decode: purely combinational mapping of (state, opCode, memReady) to outputs.
- Top-level multicycle_control holds the state register and instCount.

## Test plan
- rst pulse mid-MEM_WRITE with memReady=0 → state=0, memWrite=0, instCount=0 in the same cycle; resumes FETCH after release.
- lw (100011), memReady=1 → states 0,1,2,3,4,0; regWrite=1 and memToReg=1 only in state 4; instCount=1.
- sw (101011), memReady low for 3 cycles in state 5 → memWrite=1 for 4 cycles, then FETCH; total 7 cycles.
- Sequence R, addi, ori, beq, j → aluOp 010/000/100/001; state counts 4,4,4,3,3; instCount=5.
- Opcode 111111 → with CTRL_TRAP_EN: trap=1, pcSource=11 in state 12 for one cycle. Without it: back to FETCH after DECODE, trap=0.
- CNT_W=4, 16 fetches → instCount returns to 0.
